day_of_year_calc: RTL and testbench

DAY_OF_YEAR_CALC -- requirements
Module: day_of_year_calc

---
 rtl/day_of_year_calc.sv | 158 +++++++++++++++
 tb/tb_day_of_year_calc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/day_of_year_calc.sv
// day_of_year_calc: converts a (month, day, leap_year) date into its ordinal day of the year and
// the number of days remaining in that year. Invalid dates report valid=0 with zeroed results.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - synchronous active-high reset, takes priority over start
//   start       - request pulse, sampled only in IDLE
//   leap_year   - 1 = the requested year is a leap year
//   month       - month number, legal range 1..12
//   day         - day of month, legal range 1..days_in_month
//   busy        - high while validating or accumulating
//   done        - single-cycle completion pulse
//   valid       - last completed request was a legal date
//   day_of_year - ordinal day 1..366, 0 when invalid
//   days_left   - days remaining after day_of_year, 0 when invalid
module day_of_year_calc (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       leap_year,
  input  logic [3:0] month,
  input  logic [4:0] day,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [8:0] day_of_year,
  output logic [8:0] days_left
);

  typedef enum logic [1:0] {StIdle, StValidate, StAccum, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic       leap_q, leap_d;
  logic [3:0] idx_q, idx_d;
  logic [8:0] acc_q, acc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic [8:0] doy_q, doy_d;
  logic [8:0] left_q, left_d;

  logic [8:0] doy_sum;
  logic [8:0] year_len;
  logic       date_bad;

  // Returns 0 for out-of-range months so any nonzero day fails the range check.
  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    logic [4:0] n;
    case (m)
      4'd2:                                     n = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:                  n = 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: n = 5'd31;
      default:                                  n = 5'd0;
    endcase
    return n;
  endfunction

  assign doy_sum  = acc_q + {4'd0, day_q};
  assign year_len = leap_q ? 9'd366 : 9'd365;
  assign date_bad = (month_q == 4'd0) || (month_q > 4'd12) || (day_q == 5'd0) ||
                    (day_q > days_in_month(month_q, leap_q));

  always_comb begin
    state_d = state_q;
    month_d = month_q;
    day_d   = day_q;
    leap_d  = leap_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    valid_d = valid_q;
    doy_d   = doy_q;
    left_d  = left_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          month_d = month;
          day_d   = day;
          leap_d  = leap_year;
          acc_d   = 9'd0;
          idx_d   = 4'd1;
          busy_d  = 1'b1;
          state_d = StValidate;
        end
      end
      StValidate: begin
        if (date_bad) begin
          valid_d = 1'b0;
          doy_d   = 9'd0;
          left_d  = 9'd0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          busy_d  = 1'b1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (idx_q < month_q) begin
          acc_d  = acc_q + {4'd0, days_in_month(idx_q, leap_q)};
          idx_d  = idx_q + 4'd1;
          busy_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          doy_d   = doy_sum;
          left_d  = year_len - doy_sum;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      month_q <= 4'd0;
      day_q   <= 5'd0;
      leap_q  <= 1'b0;
      idx_q   <= 4'd0;
      acc_q   <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      doy_q   <= 9'd0;
      left_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      month_q <= month_d;
      day_q   <= day_d;
      leap_q  <= leap_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      doy_q   <= doy_d;
      left_q  <= left_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign day_of_year = doy_q;
  assign days_left   = left_q;

endmodule

// File: tb/tb_day_of_year_calc.sv
module tb_day_of_year_calc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       leap_year = 1'b0;
  logic [3:0] month = 4'd0;
  logic [4:0] day = 5'd0;
  logic       busy, done, valid;
  logic [8:0] day_of_year, days_left;

  day_of_year_calc dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .leap_year  (leap_year),
    .month      (month),
    .day        (day),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .day_of_year(day_of_year),
    .days_left  (days_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_valid;
    int exp_doy;
    int exp_left;
    int exp_edge;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_doy = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("valid", int'(valid), e.exp_valid);
          check("day_of_year", int'(day_of_year), e.exp_doy);
          check("days_left", int'(days_left), e.exp_left);
          check("done_edge", cyc, e.exp_edge);
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic req(input logic [3:0] m, input logic [4:0] d, input logic lp, input int ev,
                     input int edoy, input int eleft, input int lat, input bit inject);
    exp_t e;
    @(negedge clk);
    month     = m;
    day       = d;
    leap_year = lp;
    start     = 1'b1;
    e.exp_valid = ev;
    e.exp_doy   = edoy;
    e.exp_left  = eleft;
    e.exp_edge  = cyc + 1 + lat;
    q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs: the captured copy must be used for the whole operation.
    start     = 1'b0;
    month     = 4'd15;
    day       = 5'd0;
    leap_year = ~lp;
    check("busy_after_start", int'(busy), 1);
    check("hold_doy", int'(day_of_year), last_doy);
    if (inject) begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      month = 4'd1;
      day   = 5'd1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
    last_doy = edoy;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_doy", int'(day_of_year), 0);
    check("rst_left", int'(days_left), 0);

    //   month  day    leap  valid doy  left lat inject
    req(4'd3,  5'd1,  1'b1, 1,    61,  305, 4,  1'b0);
    req(4'd12, 5'd31, 1'b0, 1,    365, 0,   13, 1'b0);
    req(4'd2,  5'd29, 1'b0, 0,    0,   0,   1,  1'b0);
    req(4'd2,  5'd29, 1'b1, 1,    60,  306, 3,  1'b0);
    req(4'd13, 5'd5,  1'b0, 0,    0,   0,   1,  1'b0);
    req(4'd1,  5'd1,  1'b0, 1,    1,   364, 2,  1'b0);
    req(4'd4,  5'd31, 1'b0, 0,    0,   0,   1,  1'b0);
    req(4'd12, 5'd31, 1'b1, 1,    366, 0,   13, 1'b0);
    req(4'd5,  5'd0,  1'b1, 0,    0,   0,   1,  1'b0);
    req(4'd0,  5'd10, 1'b0, 0,    0,   0,   1,  1'b0);
    req(4'd7,  5'd4,  1'b0, 1,    185, 180, 8,  1'b0);

    // Reset in the middle of accumulation: outputs cleared, no done pulse.
    @(negedge clk);
    month = 4'd9;
    day   = 5'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_doy", int'(day_of_year), 0);
    check("midrst_left", int'(days_left), 0);
    repeat (15) @(posedge clk);
    last_doy = 0;

    req(4'd1,  5'd1,  1'b0, 1,    1,   364, 2,  1'b0);
    // Second start at E2 must be ignored: 243 + 15 = 258.
    req(4'd9,  5'd15, 1'b0, 1,    258, 107, 10, 1'b1);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
